adxl362_ascii_cmd_parser: RTL and testbench
===========================================

// Module: adxl362_ascii_cmd_parser
// PURPOSE
//  Receives a console ASCII byte stream from the UART RX path and decodes it into
//  ADXL362 register-access and display commands. It is the inbound complement of
//  the readings-to-ASCII text path: text goes in, binary command fields come out.
//  It sits between the UART RX byte stream and the ADXL362 SPI command FSM.
// PARAMETERS
//  parameter_addr_max       8'h2E       highest legal register address; above it -> error
//  parameter_timeout_cycles 20_000_000  idle cycles allowed mid-command (1 s @ 20 MHz)
// PORTS
//  i_clk_20mhz   in   1  system clock
//  i_rstn_20mhz  in   1  reset, asynchronous assert, active-low
//  i_rx_data     in   8  received ASCII byte
//  i_rx_valid    in   1  byte available
//  o_rx_ready    out  1  parser accepts the byte this cycle
//  o_cmd_valid   out  1  decoded command pending
//  i_cmd_ready   in   1  consumer accepts the command
//  o_cmd_op      out  2  OP_WRITE=01, OP_READ=10, OP_DISP=11
//  o_cmd_addr    out  8  register address
//  o_cmd_data    out  8  write data (00 for READ/DISP)
//  o_cmd_err     out  1  one-cycle pulse: malformed, out-of-range or timed-out line
//  o_echo_data   out  8  echo byte (ADXL362_ASCII_CMD_ECHO_EN only)
//  o_echo_valid  out  1  echo byte pending (ADXL362_ASCII_CMD_ECHO_EN only)
//  i_echo_ready  in   1  UART TX accepts the echo byte (ADXL362_ASCII_CMD_ECHO_EN only)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except o_rx_ready=1; timeout counter 0.
//  Byte transfer: occurs when i_rx_valid & o_rx_ready on a rising edge.
//  Grammar, one command per line, terminated by CR (8'h0D):
//   'W' AH AL DH DL CR = write; 'R' AH AL CR = read; 'D' CR = display-mode toggle.
//  Hex digits: 0-9, A-F and a-f.
//  LF (8'h0A) and space (8'h20) in IDLE are consumed and ignored.
//  Opcode letters are case-insensitive.
//  States:
//   IDLE -> ADDR_HI on W/R; WAIT_CR on D; drops other characters and stays in IDLE.
//   ADDR_HI -> ADDR_LO -> (W: DATA_HI -> DATA_LO ->) WAIT_CR.
//   WAIT_CR: CR -> ISSUE.
//   ERROR: drains bytes until CR, then pulses o_cmd_err and returns to IDLE.
//  Any unexpected byte in ADDR_HI..WAIT_CR -> ERROR. This includes a CR arriving early.
//  Address check: at CR, if addr > parameter_addr_max, go to IDLE with an o_cmd_err
//   pulse instead of ISSUE.
//  Latency: CR accepted at edge N -> o_cmd_valid=1 from cycle N+1.
//  Command handshake: o_cmd_valid stays high with op/addr/data stable until
//   i_cmd_ready; the cycle after that handshake o_cmd_valid=0 and state=IDLE.
//  Backpressure: o_rx_ready=0 while in ISSUE.
//  Timeout: counter clears on each accepted byte and increments in non-IDLE,
//   non-ISSUE states. When it reaches parameter_timeout_cycles-1: o_cmd_err
//   pulses and state returns to IDLE. The counter saturates and never wraps.
//  Simultaneous events: a byte accepted on the terminal timeout cycle is discarded.
//   Reset mid-command aborts with no o_cmd_valid and no o_cmd_err.
//  Nibble assembly: addr = {AH,AL}, data = {DH,DL}; both fields clear on IDLE entry.
// CONFIGURATION
//  ADXL362_ASCII_CMD_ECHO_EN defined:
//   - Every accepted byte is copied into a 1-entry echo buffer; CR echoes as CR then LF.
//   - o_rx_ready=0 while the buffer is occupied (so only in ISSUE or echo-full).
//   - o_echo_valid is held until i_echo_ready.
//  ADXL362_ASCII_CMD_ECHO_EN undefined:
//   - The echo ports are still present; o_echo_valid=0 and o_echo_data=0.
//   - i_echo_ready is ignored; no buffer logic is built.
// STRUCTURE
//  Package adxl362_ascii_cmd_pkg holds:
//   - t_cmd_state enum and t_cmd_op enum;
//   - ASCII constants (CR, LF, SP, 'W', 'R', 'D');
//   - function hex_nibble_of_ascii returning {valid, nibble[3:0]}.
//  Sub-module adxl362_ascii_echo_buffer (single-entry valid/ready skid with CR->CR,LF
//   expansion) is instantiated only under ADXL362_ASCII_CMD_ECHO_EN.
// TESTING
//  1. "W2D0A\r", i_cmd_ready=1 -> one o_cmd_valid cycle; op=01, addr=2D, data=0A;
//     no o_cmd_err.
//  2. "r0b\r" with i_cmd_ready held low for 5 cycles:
//     - o_cmd_valid high for 6 cycles; op=10, addr=0B, data=00;
//     - o_rx_ready=0 throughout; the byte offered meanwhile is taken afterwards.
//  3. "W2G\r" -> ERROR on 'G', one o_cmd_err pulse after CR, no o_cmd_valid.
//     A following "D\r" gives op=11.
//  4. "R3F\r" -> o_cmd_err pulse (3F > 2E), no o_cmd_valid.
//     "W2E" then CR on the exact timeout cycle -> o_cmd_err only.
//  5. "W2" then idle parameter_timeout_cycles (set to 16) -> o_cmd_err at cycle 16.
//     A following "R00\r" decodes cleanly.
//  6. ECHO_EN, i_echo_ready low 3 cycles per byte, "D\r":
//     - echo stream is 'D', CR, LF;
//     - o_rx_ready stalls while the echo buffer is full;
//     - mid-"W1" reset -> all outputs return to reset values.

Source files
------------

// File: rtl/adxl362_ascii_cmd_pkg.sv
// adxl362_ascii_cmd_pkg: shared states, opcodes, ASCII constants and hex decode
// for the ADXL362 console command parser and its echo buffer.
package adxl362_ascii_cmd_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA_HI, S_DATA_LO, S_WAIT_CR, S_ISSUE, S_ERROR
  } t_cmd_state;
  typedef enum logic [1:0] {
    OP_NONE = 2'b00, OP_WRITE = 2'b01, OP_READ = 2'b10, OP_DISP = 2'b11
  } t_cmd_op;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_W  = 8'h57;
  localparam logic [7:0] ASC_R  = 8'h52;
  localparam logic [7:0] ASC_D  = 8'h44;
  // Returns {valid, nibble}; letters A-F/a-f share low bits, offset by 9.
  function automatic logic [4:0] hex_nibble_of_ascii(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) ? {1'b1, c[3:0]} :
           ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) ? {1'b1, c[3:0] + 4'd9} :
           5'd0;
  endfunction
endpackage

// File: rtl/adxl362_ascii_echo_buffer.sv
// adxl362_ascii_echo_buffer: single-entry echo holding register with valid/ready
// output; a CR is replayed as CR followed by LF before the entry frees up.
module adxl362_ascii_echo_buffer
  import adxl362_ascii_cmd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_full,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready
);
  logic       r_valid, r_lf;
  logic [7:0] r_data;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_valid <= 1'b0;
      r_lf    <= 1'b0;
      r_data  <= '0;
    end else if (i_valid && !r_valid) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_lf    <= i_data == ASC_CR;
    end else if (r_valid && i_ready) begin
      r_valid <= r_lf;
      r_data  <= r_lf ? ASC_LF : r_data;
      r_lf    <= 1'b0;
    end
  end
  assign o_full  = r_valid;
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/adxl362_ascii_cmd_parser.sv
// adxl362_ascii_cmd_parser: decodes console lines (W AH AL DH DL CR / R AH AL CR / D CR)
// into ADXL362 command fields; define ADXL362_ASCII_CMD_ECHO_EN to echo accepted bytes.
module adxl362_ascii_cmd_parser
  import adxl362_ascii_cmd_pkg::*;
#(
  parameter logic [7:0] parameter_addr_max       = 8'h2E,
  parameter int         parameter_timeout_cycles = 20_000_000
) (
  input  logic       i_clk_20mhz,
  input  logic       i_rstn_20mhz,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_rx_ready,
  output logic       o_cmd_valid,
  input  logic       i_cmd_ready,
  output logic [1:0] o_cmd_op,
  output logic [7:0] o_cmd_addr,
  output logic [7:0] o_cmd_data,
  output logic       o_cmd_err,
  output logic [7:0] o_echo_data,
  output logic       o_echo_valid,
  input  logic       i_echo_ready
);
  localparam int TW = $clog2(parameter_timeout_cycles) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(parameter_timeout_cycles - 1);
  t_cmd_state    r_state, w_next;
  t_cmd_op       r_op, w_op_in;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_addr, r_data, w_up;
  logic [4:0]    w_hex;
  logic          r_err, w_err, w_accept, w_byte, w_busy, w_tmo_hit, w_cr, w_addr_bad, w_echo_full;
`ifdef ADXL362_ASCII_CMD_ECHO_EN
  adxl362_ascii_echo_buffer u_echo (
    .i_clk   (i_clk_20mhz),
    .i_rstn  (i_rstn_20mhz),
    .i_data  (i_rx_data),
    .i_valid (w_accept),
    .o_full  (w_echo_full),
    .o_data  (o_echo_data),
    .o_valid (o_echo_valid),
    .i_ready (i_echo_ready)
  );
`else
  logic w_unused_echo_ready;
  assign w_unused_echo_ready = i_echo_ready;
  assign w_echo_full  = 1'b0;
  assign o_echo_data  = '0;
  assign o_echo_valid = 1'b0;
`endif
  assign o_rx_ready = (r_state != S_ISSUE) && !w_echo_full;
  assign w_accept   = i_rx_valid && o_rx_ready;
  assign w_busy     = (r_state != S_IDLE) && (r_state != S_ISSUE);
  assign w_tmo_hit  = w_busy && (r_tmo == TMO_LAST);
  // A byte landing on the terminal timeout cycle is dropped.
  assign w_byte     = w_accept && !w_tmo_hit;
  assign w_hex      = hex_nibble_of_ascii(i_rx_data);
  assign w_cr       = i_rx_data == ASC_CR;
  assign w_up       = i_rx_data & 8'hDF;
  assign w_op_in    = (w_up == ASC_W) ? OP_WRITE : (w_up == ASC_R) ? OP_READ :
                      (w_up == ASC_D) ? OP_DISP : OP_NONE;
  assign w_addr_bad = r_addr > parameter_addr_max;
  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    if (w_tmo_hit) begin
      w_next = S_IDLE;
      w_err  = 1'b1;
    end else if (r_state == S_ISSUE) begin
      w_next = i_cmd_ready ? S_IDLE : S_ISSUE;
    end else if (w_byte) begin
      case (r_state)
        S_IDLE:    w_next = (w_op_in == OP_NONE) ? S_IDLE : (w_op_in == OP_DISP) ? S_WAIT_CR : S_ADDR_HI;
        S_ADDR_HI: w_next = w_hex[4] ? S_ADDR_LO : S_ERROR;
        S_ADDR_LO: w_next = !w_hex[4] ? S_ERROR : (r_op == OP_WRITE) ? S_DATA_HI : S_WAIT_CR;
        S_DATA_HI: w_next = w_hex[4] ? S_DATA_LO : S_ERROR;
        S_DATA_LO: w_next = w_hex[4] ? S_WAIT_CR : S_ERROR;
        S_WAIT_CR: begin
          w_next = !w_cr ? S_ERROR : w_addr_bad ? S_IDLE : S_ISSUE;
          w_err  = w_cr && w_addr_bad;
        end
        S_ERROR: begin
          w_next = w_cr ? S_IDLE : S_ERROR;
          w_err  = w_cr;
        end
        default:   w_next = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err;
      r_tmo   <= (w_accept || !w_busy) ? '0 : (r_tmo == TMO_LAST) ? r_tmo : r_tmo + 1'b1;
    end
  end
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      r_op   <= OP_NONE;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_next == S_IDLE) begin
      r_op   <= OP_NONE;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_byte) begin
      r_op   <= (r_state == S_IDLE) ? w_op_in : r_op;
      r_addr <= (r_state == S_ADDR_HI) ? {w_hex[3:0], r_addr[3:0]} :
                (r_state == S_ADDR_LO) ? {r_addr[7:4], w_hex[3:0]} : r_addr;
      r_data <= (r_state == S_DATA_HI) ? {w_hex[3:0], r_data[3:0]} :
                (r_state == S_DATA_LO) ? {r_data[7:4], w_hex[3:0]} : r_data;
    end
  end
  assign o_cmd_valid = r_state == S_ISSUE;
  assign o_cmd_op    = r_op;
  assign o_cmd_addr  = r_addr;
  assign o_cmd_data  = r_data;
  assign o_cmd_err   = r_err;
endmodule

// File: tb/tb_adxl362_ascii_cmd_parser.sv
// tb_adxl362_ascii_cmd_parser: directed scoreboard bench for the ASCII command parser,
// timeout shortened to 16 cycles; echo checks follow ADXL362_ASCII_CMD_ECHO_EN.
module tb_adxl362_ascii_cmd_parser;
  import adxl362_ascii_cmd_pkg::*;
  typedef struct packed {
    logic       kind;
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;
  logic       clk = 1'b0, rstn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0, cmd_ready = 1'b1, echo_ready = 1'b0;
  logic       o_rx_ready, o_cmd_valid, o_cmd_err, o_echo_valid;
  logic [1:0] o_cmd_op;
  logic [7:0] o_cmd_addr, o_cmd_data, o_echo_data;
  ev_t        exp_q[$];
  ev_t        mon_obs, mon_exp;
  logic [7:0] echo_q[$];
  int         checks = 0, errors = 0, vcnt = 0, v0 = 0, echo_wait = 0;

  adxl362_ascii_cmd_parser #(
    .parameter_addr_max      (8'h2E),
    .parameter_timeout_cycles(16)
  ) dut (
    .i_clk_20mhz (clk),
    .i_rstn_20mhz(rstn),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_rx_ready  (o_rx_ready),
    .o_cmd_valid (o_cmd_valid),
    .i_cmd_ready (cmd_ready),
    .o_cmd_op    (o_cmd_op),
    .o_cmd_addr  (o_cmd_addr),
    .o_cmd_data  (o_cmd_data),
    .o_cmd_err   (o_cmd_err),
    .o_echo_data (o_echo_data),
    .o_echo_valid(o_echo_valid),
    .i_echo_ready(echo_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input t_cmd_op op, input logic [7:0] addr, input logic [7:0] data);
    exp_q.push_back({1'b0, op, addr, data});
  endtask

  task automatic push_err();
    exp_q.push_back({1'b1, 18'h0});
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!o_rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rx_accept_in_time", n < 200, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Scoreboard: every handshaken command and every error pulse pops one expectation.
  always @(negedge clk) begin
    if (rstn) begin
      if (o_cmd_valid) vcnt++;
      if ((o_cmd_valid && cmd_ready) || o_cmd_err) begin
        mon_obs = o_cmd_err ? {1'b1, 18'h0} : {1'b0, o_cmd_op, o_cmd_addr, o_cmd_data};
        chk("event_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          chk("event", 32'(mon_obs), 32'(mon_exp));
        end
      end
    end
  end

`ifdef ADXL362_ASCII_CMD_ECHO_EN
  // Echo sink: holds ready low for 3 cycles of each offered byte.
  initial begin
    forever begin
      @(negedge clk);
      if (o_echo_valid && !echo_ready) begin
        echo_wait++;
        if (echo_wait > 3) begin
          echo_ready = 1'b1;
          echo_q.push_back(o_echo_data);
        end
      end else begin
        echo_ready = 1'b0;
        echo_wait  = 0;
      end
    end
  end
`endif

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", o_rx_ready, 1);
    chk("rst_cmd_valid", o_cmd_valid, 0);
    chk("rst_cmd_err", o_cmd_err, 0);
    chk("rst_fields", {o_cmd_op, o_cmd_addr, o_cmd_data}, 0);
    chk("rst_echo", {o_echo_valid, o_echo_data}, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    // write with immediate consumer
    push_cmd(OP_WRITE, 8'h2D, 8'h0A);
    send_str("W2D0A");
    send(ASC_CR);
    chk("t1_latency", o_cmd_valid, 1);
    @(posedge clk);
    #1;
    chk("t1_valid_drop", o_cmd_valid, 0);
    // lowercase read held off by consumer for 5 cycles, byte offered meanwhile
    cmd_ready = 1'b0;
    push_cmd(OP_READ, 8'h0B, 8'h00);
    push_cmd(OP_DISP, 8'h00, 8'h00);
    send_str("r0b");
    send(ASC_CR);
    v0       = vcnt;
    rx_data  = ASC_D;
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_backpressure", o_rx_ready, 0);
    end
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("t2_backpressure", o_rx_ready, 0);
    n = 0;
    while (!o_rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t2_held_byte_taken", n < 200, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk("t2_valid_cycles", vcnt - v0, 6);
    send(ASC_CR);
    // bad hex digit, then display command
    push_err();
    send_str("W2G");
    send(ASC_CR);
    chk("t3_err_pulse", o_cmd_err, 1);
    @(posedge clk);
    #1;
    chk("t3_err_one_cycle", o_cmd_err, 0);
    push_cmd(OP_DISP, 8'h00, 8'h00);
    send("D");
    send(ASC_CR);
    // address range: 3F rejected, 2E accepted
    push_err();
    send_str("R3F");
    send(ASC_CR);
    chk("t4_range_err", o_cmd_err, 1);
    chk("t4_range_no_valid", o_cmd_valid, 0);
    push_cmd(OP_READ, 8'h2E, 8'h00);
    send_str("R2E");
    send(ASC_CR);
    // CR on the terminal timeout cycle is discarded
    push_err();
    send_str("W2E");
    repeat (15) @(posedge clk);
    #1;
    send(ASC_CR);
    chk("t4_tmo_cr_err", o_cmd_err, 1);
    chk("t4_tmo_cr_no_valid", o_cmd_valid, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_tmo_cr_still_idle", o_cmd_valid, 0);
    // mid-command timeout fires exactly 16 cycles after the last byte
    push_err();
    send_str("W2");
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      chk("t5_timeout_cycle", o_cmd_err, k == 16);
    end
    push_cmd(OP_READ, 8'h00, 8'h00);
    send_str("R00");
    send(ASC_CR);
    // junk, space and LF in IDLE are dropped; mixed-case hex
    push_cmd(OP_WRITE, 8'h00, 8'hFF);
    send_str(" \012Xq");
    send_str("w00fF");
    send(ASC_CR);
    // early CR enters ERROR, which waits for another CR
    push_err();
    send_str("R1");
    send(ASC_CR);
    chk("early_cr_no_err_yet", o_cmd_err, 0);
    send(ASC_CR);
    chk("early_cr_err", o_cmd_err, 1);
    // reset mid-command
    send_str("W1");
    rstn = 1'b0;
    #1;
    chk("mid_rst_rx_ready", o_rx_ready, 1);
    chk("mid_rst_valid_err", {o_cmd_valid, o_cmd_err}, 0);
    chk("mid_rst_fields", {o_cmd_op, o_cmd_addr, o_cmd_data}, 0);
    chk("mid_rst_echo", {o_echo_valid, o_echo_data}, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    send(ASC_CR);
    push_cmd(OP_READ, 8'h05, 8'h00);
    send_str("R05");
    send(ASC_CR);
    repeat (20) @(posedge clk);
    #1;
`ifdef ADXL362_ASCII_CMD_ECHO_EN
    echo_q.delete();
    push_cmd(OP_DISP, 8'h00, 8'h00);
    send("D");
    @(negedge clk);
    chk("echo_full_stall", o_rx_ready, 0);
    chk("echo_valid", o_echo_valid, 1);
    chk("echo_data_d", o_echo_data, ASC_D);
    send(ASC_CR);
    repeat (30) @(posedge clk);
    #1;
    chk("echo_count", echo_q.size(), 3);
    chk("echo_0", echo_q[0], ASC_D);
    chk("echo_1", echo_q[1], ASC_CR);
    chk("echo_2", echo_q[2], ASC_LF);
`else
    push_cmd(OP_DISP, 8'h00, 8'h00);
    send("D");
    chk("echo_off", {o_echo_valid, o_echo_data}, 0);
    send(ASC_CR);
`endif
    repeat (20) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
